// File: rtl/elevator_ctrl.sv
// ----------------------------------------------------------------------------
// elevator_ctrl
//   Floor sequencer for a 6-stop car (F1, F2, F2M, F3, F3M, F4).
//   - Latches call requests.
//   - Moves the car one stop every TRAVEL_CYCLES clocks using SCAN ordering.
//   - Holds the door open for DOOR_CYCLES clocks at each served stop.
//   All outputs are registered.
//
// Ports
//   clk        in   1  system clock, rising edge
//   reset      in   1  asynchronous reset, active low
//   req        in   6  call requests, bit0 = F1 .. bit5 = F4
//   estop      in   1  emergency stop (only when ELEV_ESTOP_EN is defined)
//   currentF   out  6  one-hot car position
//   pending    out  6  latched, not-yet-served requests
//   up         out  1  car moving toward F4
//   down       out  1  car moving toward F1
//   door_open  out  1  door open at currentF
//
// Build option
//   ELEV_ESTOP_EN : adds the estop input.
//                   While estop is high:
//                   - the state, timer and position are frozen;
//                   - requests keep latching;
//                   - up and down are forced low.
//
// State table
//   state  | meaning
//   S_IDLE | car stopped, door closed, choosing the next move
//   S_MOVE | travelling one stop per TRAVEL_CYCLES in direction dir_q
//   S_DOOR | door open at currentF for DOOR_CYCLES clocks
// ----------------------------------------------------------------------------
module elevator_ctrl #(
   parameter int TRAVEL_CYCLES = 4,
   parameter int DOOR_CYCLES   = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] req,
`ifdef ELEV_ESTOP_EN
   input  logic       estop,
`endif
   output logic [5:0] currentF,
   output logic [5:0] pending,
   output logic       up,
   output logic       down,
   output logic       door_open
);

   localparam int TMAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
   localparam int TW   = $clog2(TMAX + 1);
   localparam logic [TW-1:0] TRAVEL_LAST = TW'(TRAVEL_CYCLES - 1);
   localparam logic [TW-1:0] DOOR_LAST   = TW'(DOOR_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MOVE = 2'd1,
      S_DOOR = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic          dir_up_q, dir_up_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [5:0]    pos_q, pos_d;
   logic [5:0]    pend_q, pend_d;
   logic          up_q, up_d;
   logic          down_q, down_d;
   logic          door_q, door_d;
   logic          freeze;

`ifdef ELEV_ESTOP_EN
   assign freeze = estop;
`else
   assign freeze = 1'b0;
`endif

   // For a one-hot position c:
   //   c - 1        sets every bit below c;
   //   ~(c | c - 1) sets every bit above c.
   function automatic logic [5:0] above_mask(input logic [5:0] c);
      return ~(c | (c - 6'd1));
   endfunction

   function automatic logic [5:0] below_mask(input logic [5:0] c);
      return c - 6'd1;
   endfunction

   function automatic logic [TW-1:0] sat_inc(input logic [TW-1:0] t);
      return (t == {TW{1'b1}}) ? t : t + 1'b1;
   endfunction

   logic [5:0] req_all;
   logic [5:0] shifted;

   assign req_all = pend_q | req;

   // Shift one stop in the travel direction, pinned at the end stops.
   always_comb begin
      shifted = pos_q;
      if (dir_up_q) begin
         if (!pos_q[5]) shifted = {pos_q[4:0], 1'b0};
      end else begin
         if (!pos_q[0]) shifted = {1'b0, pos_q[5:1]};
      end
   end

   always_comb begin
      state_d  = state_q;
      dir_up_d = dir_up_q;
      timer_d  = timer_q;
      pos_d    = pos_q;
      pend_d   = req_all;

      if (!freeze) begin
         case (state_q)
            S_IDLE: begin
               // A call for the stop the car is at is served now, never latched.
               pend_d  = req_all & ~pos_q;
               timer_d = '0;
               if ((req_all & pos_q) != 6'd0) begin
                  state_d = S_DOOR;
               end else if (((pend_q & above_mask(pos_q)) != 6'd0) &&
                            (dir_up_q || ((pend_q & below_mask(pos_q)) == 6'd0))) begin
                  state_d  = S_MOVE;
                  dir_up_d = 1'b1;
               end else if ((pend_q & below_mask(pos_q)) != 6'd0) begin
                  state_d  = S_MOVE;
                  dir_up_d = 1'b0;
               end
            end
            S_MOVE: begin
               if (timer_q >= TRAVEL_LAST) begin
                  pos_d   = shifted;
                  timer_d = '0;
                  // A call arriving on the same clock as the car reaches that
                  // stop is counted, so it is served rather than left pending.
                  if ((req_all & shifted) != 6'd0) begin
                     state_d = S_DOOR;
                     pend_d  = req_all & ~shifted;
                  end else if ((req_all & (dir_up_q ? above_mask(shifted)
                                                    : below_mask(shifted))) != 6'd0) begin
                     state_d = S_MOVE;
                  end else begin
                     state_d = S_IDLE;
                  end
               end else begin
                  timer_d = sat_inc(timer_q);
               end
            end
            S_DOOR: begin
               pend_d = req_all & ~pos_q;
               // A repeated call at this stop holds the door open.
               if ((req & pos_q) != 6'd0) begin
                  timer_d = '0;
               end else if (timer_q >= DOOR_LAST) begin
                  state_d = S_IDLE;
                  timer_d = '0;
               end else begin
                  timer_d = sat_inc(timer_q);
               end
            end
            default: begin
               state_d = S_IDLE;
               timer_d = '0;
            end
         endcase
      end

      up_d   = (state_d == S_MOVE) && dir_up_d && !freeze;
      down_d = (state_d == S_MOVE) && !dir_up_d && !freeze;
      door_d = (state_d == S_DOOR);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         dir_up_q <= 1'b1;
         timer_q  <= '0;
         pos_q    <= 6'b000001;
         pend_q   <= 6'd0;
         up_q     <= 1'b0;
         down_q   <= 1'b0;
         door_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         dir_up_q <= dir_up_d;
         timer_q  <= timer_d;
         pos_q    <= pos_d;
         pend_q   <= pend_d;
         up_q     <= up_d;
         down_q   <= down_d;
         door_q   <= door_d;
      end
   end

   assign currentF  = pos_q;
   assign pending   = pend_q;
   assign up        = up_q;
   assign down      = down_q;
   assign door_open = door_q;

endmodule

// File: tb/tb_elevator_ctrl.sv
// ----------------------------------------------------------------------------
// tb_elevator_ctrl
//   Directed testbench for elevator_ctrl (TRAVEL_CYCLES = 4, DOOR_CYCLES = 3).
//
//   Timing reference: k counts rising edges after the edge that samples the
//   first request (k = 0). Outputs are sampled 1 time unit after each edge.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_elevator_ctrl;

   logic       clk;
   logic       reset;
   logic [5:0] req;
   logic       estop;
   logic [5:0] currentF;
   logic [5:0] pending;
   logic       up;
   logic       down;
   logic       door_open;

   int checks;
   int fails;

   elevator_ctrl #(.TRAVEL_CYCLES(4), .DOOR_CYCLES(3)) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
`ifdef ELEV_ESTOP_EN
      .estop     (estop),
`endif
      .currentF  (currentF),
      .pending   (pending),
      .up        (up),
      .down      (down),
      .door_open (door_open)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic do_reset();
      reset = 1'b0;
      req   = 6'd0;
      estop = 1'b0;
      ticks(2);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({currentF, pending, up, down, door_open} !== {6'b000001, 6'd0, 3'b000}) begin
         fails++;
         $display("FAIL reset_state: got cf=%b pend=%b u/d/door=%b%b%b, want 000001 000000 000",
                  currentF, pending, up, down, door_open);
      end

      // Start a trip toward F3, then pull reset low while the car is moving.
      req = 6'b001000;
      tick();
      req = 6'd0;
      ticks(7);
      checks++;
      if (up !== 1'b1 || currentF !== 6'b000010) begin
         fails++;
         $display("FAIL reset_premove: got up=%b cf=%b, want 1 000010", up, currentF);
      end
      reset = 1'b0;
      #1;
      checks++;
      if ({currentF, pending, up, down, door_open} !== {6'b000001, 6'd0, 3'b000}) begin
         fails++;
         $display("FAIL reset_midmove: got cf=%b pend=%b u/d/door=%b%b%b, want 000001 000000 000",
                  currentF, pending, up, down, door_open);
      end
      reset = 1'b1;
   endtask

   task automatic test_travel();
      do_reset();
      req = 6'b001000;
      tick();                                          // k=0
      req = 6'd0;
      checks++;
      if (pending !== 6'b001000 || up !== 1'b0) begin
         fails++;
         $display("FAIL travel_latch: got pend=%b up=%b, want 001000 0", pending, up);
      end

      tick();                                          // k=1
      checks++;
      if (up !== 1'b1 || currentF !== 6'b000001) begin
         fails++;
         $display("FAIL travel_start: got up=%b cf=%b, want 1 000001", up, currentF);
      end

      ticks(3);                                        // k=4
      checks++;
      if (currentF !== 6'b000001) begin
         fails++;
         $display("FAIL travel_k4: got cf=%b, want 000001", currentF);
      end

      tick();                                          // k=5
      checks++;
      if (currentF !== 6'b000010 || up !== 1'b1) begin
         fails++;
         $display("FAIL travel_f2: got cf=%b up=%b, want 000010 1", currentF, up);
      end

      ticks(4);                                        // k=9
      checks++;
      if (currentF !== 6'b000100) begin
         fails++;
         $display("FAIL travel_f2m: got cf=%b, want 000100", currentF);
      end

      ticks(4);                                        // k=13
      checks++;
      if ({currentF, door_open, up, pending} !== {6'b001000, 1'b1, 1'b0, 6'd0}) begin
         fails++;
         $display("FAIL travel_f3: got cf=%b door=%b up=%b pend=%b, want 001000 1 0 000000",
                  currentF, door_open, up, pending);
      end

      ticks(2);                                        // k=15
      checks++;
      if (door_open !== 1'b1) begin
         fails++;
         $display("FAIL travel_door3: got door=%b, want 1", door_open);
      end

      tick();                                          // k=16
      checks++;
      if ({door_open, up, down} !== 3'b000) begin
         fails++;
         $display("FAIL travel_idle: got door/up/down=%b%b%b, want 000", door_open, up, down);
      end

      tick();                                          // k=17
      checks++;
      if ({up, down, currentF} !== {2'b00, 6'b001000}) begin
         fails++;
         $display("FAIL travel_stay: got up/down=%b%b cf=%b, want 00 001000", up, down, currentF);
      end
   endtask

   task automatic test_reverse();
      do_reset();
      req = 6'b100000;
      tick();                                          // k=0
      req = 6'd0;
      ticks(9);                                        // k=9
      req = 6'b000001;
      tick();                                          // k=10
      req = 6'd0;

      ticks(3);                                        // k=13
      checks++;
      if ({currentF, up, pending} !== {6'b001000, 1'b1, 6'b100001}) begin
         fails++;
         $display("FAIL reverse_f3: got cf=%b up=%b pend=%b, want 001000 1 100001",
                  currentF, up, pending);
      end

      ticks(8);                                        // k=21
      checks++;
      if ({currentF, door_open, up, pending} !== {6'b100000, 1'b1, 1'b0, 6'b000001}) begin
         fails++;
         $display("FAIL reverse_f4: got cf=%b door=%b up=%b pend=%b, want 100000 1 0 000001",
                  currentF, door_open, up, pending);
      end

      ticks(3);                                        // k=24
      checks++;
      if ({door_open, up, down} !== 3'b000) begin
         fails++;
         $display("FAIL reverse_idle: got door/up/down=%b%b%b, want 000", door_open, up, down);
      end

      tick();                                          // k=25
      checks++;
      if ({up, down} !== 2'b01) begin
         fails++;
         $display("FAIL reverse_down: got up/down=%b%b, want 01", up, down);
      end

      ticks(19);                                       // k=44
      checks++;
      if ({currentF, down} !== {6'b000010, 1'b1}) begin
         fails++;
         $display("FAIL reverse_f2: got cf=%b down=%b, want 000010 1", currentF, down);
      end

      tick();                                          // k=45
      checks++;
      if ({currentF, door_open, down, pending} !== {6'b000001, 1'b1, 1'b0, 6'd0}) begin
         fails++;
         $display("FAIL reverse_f1: got cf=%b door=%b down=%b pend=%b, want 000001 1 0 000000",
                  currentF, door_open, down, pending);
      end
   endtask

   task automatic test_same_floor();
      do_reset();
      req = 6'b000001;
      tick();                                          // E1
      req = 6'd0;
      checks++;
      if ({door_open, pending} !== {1'b1, 6'd0}) begin
         fails++;
         $display("FAIL same_floor_open: got door=%b pend=%b, want 1 000000", door_open, pending);
      end

      tick();                                          // E2
      req = 6'b000001;
      tick();                                          // E3: door restarts here
      req = 6'd0;
      ticks(2);                                        // E5
      checks++;
      if ({door_open, pending} !== {1'b1, 6'd0}) begin
         fails++;
         $display("FAIL same_floor_held: got door=%b pend=%b, want 1 000000", door_open, pending);
      end

      tick();                                          // E6
      checks++;
      if ({door_open, pending} !== {1'b0, 6'd0}) begin
         fails++;
         $display("FAIL same_floor_close: got door=%b pend=%b, want 0 000000", door_open, pending);
      end
   endtask

   task automatic test_arrival_req();
      do_reset();
      req = 6'b001000;
      tick();                                          // k=0
      req = 6'd0;
      ticks(4);                                        // k=4
      req = 6'b000010;
      tick();                                          // k=5: reaches F2 on this edge
      req = 6'd0;
      checks++;
      if ({currentF, door_open, up, pending} !== {6'b000010, 1'b1, 1'b0, 6'b001000}) begin
         fails++;
         $display("FAIL arrival_req: got cf=%b door=%b up=%b pend=%b, want 000010 1 0 001000",
                  currentF, door_open, up, pending);
      end

      ticks(4);                                        // k=9
      checks++;
      if ({door_open, up} !== 2'b01) begin
         fails++;
         $display("FAIL arrival_resume: got door=%b up=%b, want 0 1", door_open, up);
      end
   endtask

   task automatic test_all_floors();
      int         nstops;
      logic       prev_door;
      logic       up_at_f4;
      logic       done;
      logic [5:0] expected_stop;

      nstops    = 0;
      prev_door = 1'b0;
      up_at_f4  = 1'b0;
      done      = 1'b0;

      do_reset();
      req = 6'b111111;
      for (int c = 0; c < 200 && !done; c++) begin
         tick();
         req = 6'd0;
         if (up && currentF[5]) up_at_f4 = 1'b1;
         if (door_open && !prev_door) begin
            expected_stop = 6'b000001 << nstops;
            checks++;
            if (currentF !== expected_stop) begin
               fails++;
               $display("FAIL all_floors_order: stop %0d got cf=%b, want %b",
                        nstops, currentF, expected_stop);
            end
            nstops++;
         end
         if (!door_open && prev_door && currentF[5]) done = 1'b1;
         prev_door = door_open;
      end

      checks++;
      if (done !== 1'b1 || nstops != 6) begin
         fails++;
         $display("FAIL all_floors_done: got done=%b stops=%0d, want 1 6", done, nstops);
      end

      checks++;
      if ({up_at_f4, pending} !== {1'b0, 6'd0}) begin
         fails++;
         $display("FAIL all_floors_final: got up_at_f4=%b pend=%b, want 0 000000",
                  up_at_f4, pending);
      end
   endtask

`ifdef ELEV_ESTOP_EN
   task automatic test_estop();
      do_reset();
      req = 6'b001000;
      tick();                                          // k=0
      req = 6'd0;
      ticks(2);                                        // k=2
      estop = 1'b1;
      ticks(5);                                        // k=7
      checks++;
      if ({up, currentF} !== {1'b0, 6'b000001}) begin
         fails++;
         $display("FAIL estop_frozen: got up=%b cf=%b, want 0 000001", up, currentF);
      end

      ticks(5);                                        // k=12
      estop = 1'b0;
      checks++;
      if (currentF !== 6'b000001) begin
         fails++;
         $display("FAIL estop_hold: got cf=%b, want 000001", currentF);
      end

      ticks(2);                                        // k=14
      checks++;
      if ({up, currentF} !== {1'b1, 6'b000001}) begin
         fails++;
         $display("FAIL estop_resume: got up=%b cf=%b, want 1 000001", up, currentF);
      end

      tick();                                          // k=15
      checks++;
      if (currentF !== 6'b000010) begin
         fails++;
         $display("FAIL estop_arrival: got cf=%b, want 000010", currentF);
      end
   endtask
`endif

   initial begin
      checks = 0;
      fails  = 0;
      reset  = 1'b0;
      req    = 6'd0;
      estop  = 1'b0;

      test_reset();
      test_travel();
      test_reverse();
      test_same_floor();
      test_arrival_req();
      test_all_floors();
`ifdef ELEV_ESTOP_EN
      test_estop();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
